// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg
//   Shared defaults and encodings for pattern_detector_param.
//   PAT_W_DEF     : default pattern length in bits
//   CNT_W_DEF     : default match counter width
//   RESET_PAT_DEF : pattern loaded at reset (4'b1010, zero-extended)
//   OVL_ON/OFF    : encoding of the overlap_en input
package pattern_detector_pkg;

  localparam int          PAT_W_DEF     = 4;
  localparam int          CNT_W_DEF     = 8;
  localparam logic [31:0] RESET_PAT_DEF = 32'b1010;

  localparam logic OVL_ON  = 1'b1;  // matches may share bits
  localparam logic OVL_OFF = 1'b0;  // each match needs PAT_W fresh bits

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk     : rising-edge clock
//     i_clear : synchronous clear, wins over i_inc
//     i_inc   : increment by one unless already at all-ones
//     o_count : current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear)
      r_count <= '0;
    else if (i_inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/pattern_detector_param.sv
// pattern_detector_param
//   Serial pattern detector with runtime-loadable pattern and selectable
//   overlapping / non-overlapping detection. One-cycle registered match pulse.
//   Optional feature macro: PATTERN_DETECTOR_MATCH_COUNT_EN adds the
//   saturating match_count output.
//   Ports:
//     clk         : rising-edge clock
//     reset       : synchronous active-high reset (highest priority)
//     in_valid    : in_bit is accepted this cycle
//     in_bit      : serial data, pattern MSB first
//     overlap_en  : 1 = overlapping, 0 = non-overlapping detection
//     pat_load    : load pat_in, clear progress (beats in_valid)
//     pat_in      : new pattern value
//     out         : registered match pulse
//     match_count : saturating count of out pulses (macro only)
module pattern_detector_param
  import pattern_detector_pkg::*;
#(
  parameter int               PAT_W     = PAT_W_DEF,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(RESET_PAT_DEF),
  parameter int               CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  // The window only keeps the PAT_W-1 most recent bits: the match compares
  // them together with the incoming bit, so the oldest bit of a full
  // PAT_W window would never be read.
  logic [PAT_W-2:0]  r_win;
  logic [PAT_W-1:0]  r_pat;
  logic [FILL_W-1:0] r_fill;
  logic              r_out;

  logic [PAT_W-1:0]  w_cand;
  logic              w_match;

  assign w_cand  = {r_win, in_bit};
  assign w_match = in_valid && !pat_load && (r_fill == FILL_MAX) &&
                   (w_cand == r_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= RESET_PAT;
      r_win  <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else begin
      r_out <= w_match;
      if (pat_load) begin
        // the bit presented alongside a load is dropped
        r_pat  <= pat_in;
        r_win  <= '0;
        r_fill <= '0;
      end else if (in_valid) begin
        r_win <= w_cand[PAT_W-2:0];
        // overlap_en only matters on a match: it decides whether the
        // matched bits may seed the next detection
        if (w_match && (overlap_en == OVL_OFF))
          r_fill <= '0;
        else if (r_fill != FILL_MAX)
          r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  assign out = r_out;

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
  logic w_cnt_clear;
  assign w_cnt_clear = reset || pat_load;

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk     (clk),
    .i_clear (w_cnt_clear),
    .i_inc   (r_out),
    .o_count (match_count)
  );
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
module tb_pattern_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_bit, overlap_en, pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             out;
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
  logic [CNT_W-1:0] match_count;
`endif

  pattern_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .out        (out)
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             o;
    logic [CNT_W-1:0] c;
    int               tid;
    int               sid;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_tid = 0;
  int   cur_sid = 0;

  // monitor: one expectation per clock, compared after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (out !== e.o) begin
          errors++;
          $display("FAIL out t%0d s%0d: got %b expected %b", e.tid, e.sid, out, e.o);
        end
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        checks++;
        if (match_count !== e.c) begin
          errors++;
          $display("FAIL match_count t%0d s%0d: got %0d expected %0d",
                   e.tid, e.sid, match_count, e.c);
        end
`endif
      end
    end
  end

  // drive one cycle of inputs and queue the state expected after that edge
  task automatic step(input logic rst, input logic v, input logic b,
                      input logic ovl, input logic ld, input logic [PAT_W-1:0] pin,
                      input logic eo, input int ec);
    exp_t e;
    @(negedge clk);
    reset = rst; in_valid = v; in_bit = b; overlap_en = ovl;
    pat_load = ld; pat_in = pin;
    e.o = eo; e.c = CNT_W'(ec); e.tid = cur_tid; e.sid = cur_sid;
    q.push_back(e);
    cur_sid++;
  endtask

  task automatic bit_in(input logic b, input logic ovl, input logic eo, input int ec);
    step(1'b0, 1'b1, b, ovl, 1'b0, '0, eo, ec);
  endtask

  task automatic idle(input logic ovl, input logic eo, input int ec);
    step(1'b0, 1'b0, 1'b0, ovl, 1'b0, '0, eo, ec);
  endtask

  task automatic do_reset(input int tid);
    cur_tid = tid; cur_sid = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap_en = 1'b1;
    pat_load = 1'b0; pat_in = '0;

    // t1: overlap, 101010 -> pulses after bits 4 and 6, count 2
    do_reset(1);
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0);
    bit_in(0, 1, 1, 0); bit_in(1, 1, 0, 1); bit_in(0, 1, 1, 1);
    idle(1, 0, 2); idle(1, 0, 2);

    // t2: non-overlap, same stream -> single pulse, count 1
    do_reset(2);
    bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
    bit_in(0, 0, 1, 0); bit_in(1, 0, 0, 1); bit_in(0, 0, 0, 1);
    idle(0, 0, 1);

    // t3: 3 idle cycles between bits -> one pulse after the 4th bit
    do_reset(3);
    bit_in(1, 1, 0, 0); idle(1, 0, 0); idle(1, 0, 0); idle(1, 0, 0);
    bit_in(0, 1, 0, 0); idle(1, 0, 0); idle(1, 0, 0); idle(1, 0, 0);
    bit_in(1, 1, 0, 0); idle(1, 0, 0); idle(1, 0, 0); idle(1, 0, 0);
    bit_in(0, 1, 1, 0); idle(1, 0, 1); idle(1, 0, 1);

    // t4: load 1100 with a simultaneous bit; 1100 matches, 1010 does not
    do_reset(4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, 0);
    bit_in(1, 1, 0, 0); bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0);
    bit_in(0, 1, 1, 0);
    bit_in(1, 1, 0, 1); bit_in(0, 1, 0, 1); bit_in(1, 1, 0, 1);
    bit_in(0, 1, 0, 1); idle(1, 0, 1);

    // t5: partial 101, reset, then 0 -> nothing; fill restarts at the 0
    do_reset(5);
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 0);
    bit_in(0, 1, 0, 0);
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0);
    bit_in(0, 1, 1, 0); idle(1, 0, 1);

    // t6: switch to non-overlap mid-stream; progress kept, fill cleared on match
    do_reset(6);
    bit_in(1, 1, 0, 0); bit_in(0, 1, 0, 0); bit_in(1, 1, 0, 0);
    bit_in(0, 0, 1, 0);
    bit_in(1, 0, 0, 1); bit_in(0, 0, 0, 1); bit_in(1, 0, 0, 1);
    bit_in(0, 0, 1, 1); idle(0, 0, 2);

    // t7: overlap, 1010 x4 -> 7 pulses, 2-bit count saturates at 3
    do_reset(7);
    begin
      int pulses = 0;
      for (int k = 1; k <= 16; k++) begin
        logic eo;
        eo = (k >= 4) && (k % 2 == 0);
        bit_in(logic'(k % 2), 1, eo, (pulses > 3) ? 3 : pulses);
        if (eo) pulses++;
      end
    end
    idle(1, 0, 3); idle(1, 0, 3);

    // t8: reset state after a full stream
    do_reset(8);
    idle(1, 0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detector_param.md
PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter RESET_PAT, default 4'b1010 zero-extended to PAT_W: pattern loaded at reset.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_bit is accepted this cycle.
REQ-007 SHALL have port in_bit, input, 1 bit: serial data, MSB-of-pattern first.
REQ-008 SHALL have port overlap_en, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 SHALL have port pat_load, input, 1 bit: load pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, PAT_W bits: new pattern value.
REQ-011 SHALL have port out, output, 1 bit: registered Moore match pulse.
REQ-012 SHALL have port match_count, output, CNT_W bits: saturating match count (present only per REQ-027).

Function
REQ-013 SHALL hold a PAT_W-bit window shift register, a pattern register, and a fill counter (0..PAT_W-1, saturating) of accepted bits.
REQ-014 Accept: an accepted bit SHALL shift into the window LSB; cycles with in_valid=0 SHALL leave all state unchanged except out.
REQ-015 Match condition: in_valid=1, pat_load=0, fill == PAT_W-1, and {window[PAT_W-2:0], in_bit} == pattern.
REQ-016 out SHALL be 1 in cycle t+1 iff the match condition held in cycle t; otherwise out is 0, giving exactly one 1-cycle pulse per match and 1 cycle latency.
REQ-017 Overlap mode: on a match, fill SHALL stay saturated, so matches may share bits.
REQ-018 Non-overlap mode: on a match, fill SHALL clear to 0, so a new match needs PAT_W fresh bits.
REQ-019 overlap_en SHALL be sampled only on match cycles; changing it mid-stream SHALL NOT clear state.
REQ-020 pat_load=1 SHALL load pat_in, clear the window and fill, and force out=0 next cycle.
REQ-021 pat_load SHALL take priority over a simultaneous in_valid; that bit is dropped.
REQ-022 Internal states (fill 0..PAT_W-1 combined with window) SHALL be a generalised Moore machine; no output SHALL depend combinationally on inputs.

Reset
REQ-023 reset SHALL take priority over pat_load and in_valid.
REQ-024 On reset: pattern=RESET_PAT, window=0, fill=0, out=0, match_count=0.
REQ-025 Reset asserted mid-sequence SHALL discard partial progress; no pulse SHALL issue for bits accepted before reset.
REQ-026 The first accepted bit after reset release SHALL count as fill position 0.

Configuration
REQ-027 Macro PATTERN_DETECTOR_MATCH_COUNT_EN defined: match_count SHALL increment by 1 on each cycle out=1, saturate at 2^CNT_W-1, and clear on reset or pat_load.
REQ-028 Macro undefined: the match_count port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package pattern_detector_pkg SHALL hold the defaults for PAT_W, CNT_W and RESET_PAT, and the overlap mode encoding constants.
REQ-030 Sub-module sat_counter (CNT_W parameter, inc, clear, saturating) SHALL implement match_count and SHALL be instantiated only under the macro.

Verification
REQ-031 Defaults, overlap_en=1, bits 1,0,1,0,1,0 with in_valid=1 -> out pulses the cycle after bit 4 and after bit 6; match_count=2.
REQ-032 Same stream, overlap_en=0 -> single pulse after bit 4; none after bit 6; match_count=1.
REQ-033 Bits 1,0,1,0 with in_valid=0 for 3 cycles between each bit -> exactly one pulse, the cycle after the 4th accepted bit.
REQ-034 pat_load=1 with pat_in=4'b1100 and in_valid=1, in_bit=1 in the same cycle -> bit dropped; the following 1,1,0,0 gives one pulse; 1,0,1,0 gives none.
REQ-035 Bits 1,0,1, then reset for 1 cycle, then bit 0 -> no pulse; out=0 and match_count=0 throughout reset.
REQ-036 CNT_W=2, overlap on, stream 1010101010101010 (7 matches) -> match_count reaches 3 and holds 3.
